rf_window_ctrl: RTL
===================

// Module: rf_window_ctrl
// PURPOSE
//  Register-window manager for the 64x16 windowed register file. Owns the Base pointer: push/pop/set
//  commands from the control unit move the window. When physical windows run out it spills the
//  oldest window to data memory; when a pop needs an evicted window it fills it back. It stalls the
//  core (busy) and takes over the RF L-port and memory port while a transfer runs.
// PARAMETERS
//  ADDR_W     6        RF address width (64 regs)
//  DATA_W     16       RF/memory data width
//  WIN_SIZE   4        registers per window (2-bit Laddr)
//  WIN_STEP   4        Base increment per push; NUM_WIN = 2**ADDR_W / WIN_STEP (16)
//  RESET_BASE 0        Base after reset
//  SPILL_BASE 16'hFF00 first memory word of the spill stack (grows upward)
//  SPILL_MAX  64       max windows held in memory
// PORTS
//  clk        in  1       clock, all state on posedge
//  rst        in  1       synchronous, active-high reset
//  push       in  1       advance window (call)
//  pop        in  1       retreat window (return)
//  set_base   in  1       load absolute window, clears window history
//  base_in    in  ADDR_W  value for set_base
//  base       out ADDR_W  current Base to RF/datapath
//  busy       out 1       transfer in progress; core must stall
//  depth      out 8       resident + spilled windows
//  ovf, unf   out 1       one-cycle pulses: spill stack full / pop with nothing below
//  cmd_err    out 1       one-cycle pulse: >1 command asserted in same cycle
//  rf_own     out 1       1 = RF L-port driven by this block (datapath mux select)
//  rf_base    out ADDR_W  Base for RF during transfer
//  rf_laddr   out 2       register within window
//  rf_lwrite, rf_hwrite out 1  RF byte write enables (fill only)
//  rf_wdata   out DATA_W  RF write data (fill)
//  rf_lout    in  DATA_W  RF L-port read data (spill)
//  mem_req    out 1       memory request, held until mem_ack
//  mem_we     out 1       1 = write (spill), 0 = read (fill)
//  mem_addr   out 16      word address
//  mem_wdata  out DATA_W  spill data
//  mem_rdata  in  DATA_W  fill data, valid with mem_ack
//  mem_ack    in  1       one-cycle completion
// BEHAVIOUR
//  - State: base, resident (1..NUM_WIN), spilled (0..SPILL_MAX), sp (16b), FSM IDLE/SPILL/FILL_RD/FILL_WR.
//  - Reset values: base=RESET_BASE, resident=1, spilled=0, sp=SPILL_BASE, state=IDLE; busy, rf_own,
//    rf_lwrite, rf_hwrite, mem_req, mem_we, ovf, unf, cmd_err = 0; depth=1; mem_addr=SPILL_BASE.
//  - Commands sampled only in IDLE with busy=0; commands during busy are ignored, not queued.
//    More than one of push/pop/set_base high -> cmd_err, no state change.
//  - set_base: base<=base_in, resident<=1, spilled<=0, sp<=SPILL_BASE; 1 cycle.
//  - push, resident<NUM_WIN: base<=base+WIN_STEP (mod 2**ADDR_W), resident++; visible next cycle, no busy.
//  - push, resident==NUM_WIN, spilled<SPILL_MAX: SPILL window at base+WIN_STEP (oldest), regs 0..3 to
//    mem[sp..sp+3]; then base<=base+WIN_STEP, spilled++, sp+=4. spilled==SPILL_MAX: ovf, no change.
//  - pop, resident>1: base<=base-WIN_STEP, resident--; 1 cycle. resident==1, spilled>0: FILL window at
//    base-WIN_STEP from mem[sp-1..sp-4] into regs 3..0; then base-=WIN_STEP, spilled--, sp-=4.
//    resident==1, spilled==0: unf, no change.
//  - busy and rf_own high from cycle after command through cycle base updates; base changes only at end.
//  - Each beat: mem_req=1 with addr/we/wdata stable until mem_ack; no new req in ack cycle.
//    FILL_WR: one cycle, rf_lwrite=rf_hwrite=1, rf_wdata=captured mem_rdata. Min spill 5, fill 9 cycles.
//  - rst mid-transfer: aborts; next cycle mem_req=0, rf_own=0, all state at reset values.
//  - depth = resident + spilled, 8-bit.
// STRUCTURE
//  - Package rf_win_pkg: FSM state encoding, NUM_WIN, beat count, SPILL_BASE default.
//  - One sub-module rf_win_xfer: 4-beat spill/fill sequencer (beat counter, mem handshake, RF drive);
//    top keeps base/resident/spilled/sp and command decode.
// TESTING
//  1. rst, 3 pushes -> base 0,4,8,12; depth 4; busy never high.
//  2. 15 pushes (base 60, resident 16), regs 0..3 = 16'hA000..A003, 16th push -> writes FF00..FF03 =
//     A000..A003; base 0, depth 17, sp FF04; with 3 wait states per ack, busy lasts 17 cycles.
//  3. Pop until resident 1 (base 4), pop -> reads FF03..FF00 into regs 3..0 of window 0; base 0, depth 1.
//  4. After rst, pop -> unf pulse one cycle, base 0; push+pop same cycle -> cmd_err, no change.
//  5. push asserted while busy -> ignored; set_base 16'h20 -> base 32, depth 1, sp FF00.
//  6. rst during 2nd spill beat -> next cycle mem_req=0, busy=0, base=RESET_BASE, depth 1.

Source files
------------

// File: rtl/rf_win_pkg.sv
// Shared types and defaults for the register-window manager and its
// spill/fill sequencer.
package rf_win_pkg;

  typedef enum logic [1:0] {
    XS_IDLE    = 2'd0,
    XS_SPILL   = 2'd1,
    XS_FILL_RD = 2'd2,
    XS_FILL_WR = 2'd3
  } xfer_state_e;

  localparam int          XFER_BEATS     = 4;
  localparam logic [15:0] SPILL_BASE_DEF = 16'hFF00;

  function automatic int num_win(input int addr_w, input int win_step);
    return (1 << addr_w) / win_step;
  endfunction

endpackage

// File: rtl/rf_win_xfer.sv
// Four-beat spill/fill sequencer: walks one window between the RF L-port and
// data memory, then holds busy for one commit cycle (done) so the owner can
// move its pointers.
module rf_win_xfer
  import rf_win_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 16,
  parameter int WIN_SIZE = XFER_BEATS,
  parameter int WIN_STEP = 4,
  localparam int LADDR_W = $clog2(WIN_SIZE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_spill,
  input  logic               start_fill,
  input  logic [ADDR_W-1:0]  base,
  input  logic [15:0]        sp,
  input  logic [DATA_W-1:0]  rf_lout,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ack,
  output logic               busy,
  output logic               done,
  output logic               done_fill,
  output logic               rf_own,
  output logic [ADDR_W-1:0]  rf_base,
  output logic [LADDR_W-1:0] rf_laddr,
  output logic               rf_lwrite,
  output logic               rf_hwrite,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [15:0]        mem_addr,
  output logic [DATA_W-1:0]  mem_wdata
);

  xfer_state_e        state_q, state_d;
  logic [LADDR_W-1:0] beat_q, beat_d;
  logic               fill_q, fill_d;
  logic               fin_q, fin_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               last_beat;
  logic [15:0]        beat_w;

  assign last_beat = (beat_q == LADDR_W'(WIN_SIZE - 1));
  assign beat_w    = 16'(beat_q);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    fill_d  = fill_q;
    fin_d   = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      XS_IDLE: begin
        if (start_spill) begin
          state_d = XS_SPILL;
          beat_d  = '0;
          fill_d  = 1'b0;
        end else if (start_fill) begin
          state_d = XS_FILL_RD;
          beat_d  = '0;
          fill_d  = 1'b1;
        end
      end
      XS_SPILL: begin
        if (mem_ack) begin
          if (last_beat) begin
            state_d = XS_IDLE;
            fin_d   = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      XS_FILL_RD: begin
        if (mem_ack) begin
          rdata_d = mem_rdata;
          state_d = XS_FILL_WR;
        end
      end
      XS_FILL_WR: begin
        if (last_beat) begin
          state_d = XS_IDLE;
          fin_d   = 1'b1;
        end else begin
          beat_d  = beat_q + 1'b1;
          state_d = XS_FILL_RD;
        end
      end
      default: state_d = XS_IDLE;
    endcase
  end

  // Spill targets the window just above base, fill the one just below; fill
  // walks memory downward so the top word lands in the last register.
  always_comb begin
    busy      = (state_q != XS_IDLE) || fin_q;
    done      = fin_q;
    done_fill = fill_q;
    rf_own    = busy;
    rf_base   = base;
    rf_laddr  = '0;
    if (busy) begin
      rf_base  = fill_q ? (base - ADDR_W'(WIN_STEP)) : (base + ADDR_W'(WIN_STEP));
      rf_laddr = fill_q ? (LADDR_W'(WIN_SIZE - 1) - beat_q) : beat_q;
    end
    rf_lwrite = (state_q == XS_FILL_WR);
    rf_hwrite = (state_q == XS_FILL_WR);
    rf_wdata  = rdata_q;
    mem_req   = (state_q == XS_SPILL) || (state_q == XS_FILL_RD);
    mem_we    = (state_q == XS_SPILL);
    mem_wdata = (state_q == XS_SPILL) ? rf_lout : '0;
    unique case (state_q)
      XS_SPILL:   mem_addr = sp + beat_w;
      XS_FILL_RD: mem_addr = sp - 16'd1 - beat_w;
      default:    mem_addr = sp;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= XS_IDLE;
      beat_q  <= '0;
      fill_q  <= 1'b0;
      fin_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      fill_q  <= fill_d;
      fin_q   <= fin_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: rtl/rf_window_ctrl.sv
// Register-window manager: owns Base and the resident/spilled window counts,
// decodes push/pop/set_base and hands overflowing windows to rf_win_xfer.
module rf_window_ctrl
  import rf_win_pkg::*;
#(
  parameter int              ADDR_W     = 6,
  parameter int              DATA_W     = 16,
  parameter int              WIN_SIZE   = XFER_BEATS,
  parameter int              WIN_STEP   = 4,
  parameter logic [ADDR_W-1:0] RESET_BASE = '0,
  parameter logic [15:0]     SPILL_BASE = SPILL_BASE_DEF,
  parameter int              SPILL_MAX  = 64,
  localparam int             LADDR_W    = $clog2(WIN_SIZE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               set_base,
  input  logic [ADDR_W-1:0]  base_in,
  output logic [ADDR_W-1:0]  base,
  output logic               busy,
  output logic [7:0]         depth,
  output logic               ovf,
  output logic               unf,
  output logic               cmd_err,
  output logic               rf_own,
  output logic [ADDR_W-1:0]  rf_base,
  output logic [LADDR_W-1:0] rf_laddr,
  output logic               rf_lwrite,
  output logic               rf_hwrite,
  output logic [DATA_W-1:0]  rf_wdata,
  input  logic [DATA_W-1:0]  rf_lout,
  output logic               mem_req,
  output logic               mem_we,
  output logic [15:0]        mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ack
);

  localparam int NUM_WIN = num_win(ADDR_W, WIN_STEP);
  localparam int RES_W   = $clog2(NUM_WIN + 1);
  localparam int SPL_W   = $clog2(SPILL_MAX + 1);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [RES_W-1:0]  resident_q, resident_d;
  logic [SPL_W-1:0]  spilled_q, spilled_d;
  logic [15:0]       sp_q, sp_d;
  logic              ovf_q, ovf_d, unf_q, unf_d, cmd_err_q, cmd_err_d;
  logic              start_spill, start_fill;
  logic              x_busy, x_done, x_done_fill;
  logic [1:0]        n_cmd;

  assign n_cmd = 2'(push) + 2'(pop) + 2'(set_base);

  always_comb begin
    base_d      = base_q;
    resident_d  = resident_q;
    spilled_d   = spilled_q;
    sp_d        = sp_q;
    ovf_d       = 1'b0;
    unf_d       = 1'b0;
    cmd_err_d   = 1'b0;
    start_spill = 1'b0;
    start_fill  = 1'b0;
    if (x_done) begin
      // Transfer finished: the window has moved, resident count is unchanged.
      if (x_done_fill) begin
        base_d    = base_q - ADDR_W'(WIN_STEP);
        spilled_d = spilled_q - 1'b1;
        sp_d      = sp_q - 16'(WIN_SIZE);
      end else begin
        base_d    = base_q + ADDR_W'(WIN_STEP);
        spilled_d = spilled_q + 1'b1;
        sp_d      = sp_q + 16'(WIN_SIZE);
      end
    end else if (!x_busy) begin
      if (n_cmd > 2'd1) begin
        cmd_err_d = 1'b1;
      end else if (set_base) begin
        base_d     = base_in;
        resident_d = RES_W'(1);
        spilled_d  = '0;
        sp_d       = SPILL_BASE;
      end else if (push) begin
        if (resident_q < RES_W'(NUM_WIN)) begin
          base_d     = base_q + ADDR_W'(WIN_STEP);
          resident_d = resident_q + 1'b1;
        end else if (spilled_q < SPL_W'(SPILL_MAX)) begin
          start_spill = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (pop) begin
        if (resident_q > RES_W'(1)) begin
          base_d     = base_q - ADDR_W'(WIN_STEP);
          resident_d = resident_q - 1'b1;
        end else if (spilled_q != '0) begin
          start_fill = 1'b1;
        end else begin
          unf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q     <= RESET_BASE;
      resident_q <= RES_W'(1);
      spilled_q  <= '0;
      sp_q       <= SPILL_BASE;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      base_q     <= base_d;
      resident_q <= resident_d;
      spilled_q  <= spilled_d;
      sp_q       <= sp_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  assign base    = base_q;
  assign depth   = 8'(resident_q) + 8'(spilled_q);
  assign ovf     = ovf_q;
  assign unf     = unf_q;
  assign cmd_err = cmd_err_q;
  assign busy    = x_busy;

  rf_win_xfer #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .WIN_SIZE (WIN_SIZE),
    .WIN_STEP (WIN_STEP)
  ) u_xfer (
    .clk         (clk),
    .rst         (rst),
    .start_spill (start_spill),
    .start_fill  (start_fill),
    .base        (base_q),
    .sp          (sp_q),
    .rf_lout     (rf_lout),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .busy        (x_busy),
    .done        (x_done),
    .done_fill   (x_done_fill),
    .rf_own      (rf_own),
    .rf_base     (rf_base),
    .rf_laddr    (rf_laddr),
    .rf_lwrite   (rf_lwrite),
    .rf_hwrite   (rf_hwrite),
    .rf_wdata    (rf_wdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata)
  );

endmodule
